// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes A - B - BIN one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_shift;
    logic [CW-1:0]    count;
    logic             borrow, bout_q;
    logic             bit_a, bit_b, diff_bit, borrow_nxt;

    // Full-subtractor cell; each new difference bit enters the result at the MSB.
    always_comb begin
        bit_a      = a_sr[0];
        bit_b      = b_sr[0];
        diff_bit   = bit_a ^ bit_b ^ borrow;
        borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
        d_shift    = d_sr >> 1;
        d_shift[WIDTH-1] = diff_bit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID)      state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    if (OUT_READY)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            count  <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    a_sr   <= A;
                    b_sr   <= B;
                    borrow <= BIN;
                    d_sr   <= '0;
                    count  <= '0;
                    bout_q <= 1'b0;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= borrow_nxt;
                    d_sr   <= d_shift;
                    count  <= count + CW'(1);
                    if (count == LAST) bout_q <= borrow_nxt;
                end
                default: ;
            endcase
        end
    end

    // Handshake flags come straight from state so no input reaches an output.
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign D         = d_sr;
    assign BOUT      = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed and random transactions on a 4-bit and a
// 1-bit instance, checked against plain integer subtraction.
module tb_serial_sub;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       iv4, iv1;
    logic [3:0] a, b;
    logic       bin, ordy;
    logic       ir4, ov4, bo4, ir1, ov1, bo1;
    logic [3:0] d4;
    logic [0:0] d1;
    logic       sel;
    logic       ir, ov, bo;
    logic [3:0] d;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    serial_sub #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv4), .IN_READY(ir4),
        .A(a), .B(b), .BIN(bin), .OUT_VALID(ov4), .OUT_READY(ordy),
        .D(d4), .BOUT(bo4)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv1), .IN_READY(ir1),
        .A(a[0:0]), .B(b[0:0]), .BIN(bin), .OUT_VALID(ov1), .OUT_READY(ordy),
        .D(d1), .BOUT(bo1)
    );

    assign ir = sel ? ir1 : ir4;
    assign ov = sel ? ov1 : ov4;
    assign bo = sel ? bo1 : bo4;
    assign d  = sel ? {3'b000, d1} : d4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_iv(input logic v);
        if (sel) iv1 = v;
        else     iv4 = v;
    endtask

    // Reference: exact integer difference, then reduce to WIDTH bits.
    task automatic model(input int w, input int av, input int bv, input int bnv,
                         output int dexp, output int bexp);
        int diff;
        diff = av - bv - bnv;
        bexp = (diff < 0) ? 1 : 0;
        dexp = diff & ((1 << w) - 1);
    endtask

    task automatic noise_inputs();
        a = 4'($urandom);
        b = 4'($urandom);
        bin = 1'($urandom);
        set_iv(1'($urandom_range(0, 1)));
    endtask

    // One transaction on the selected instance; called and returns at a negedge.
    task automatic xact(input int av, input int bv, input int bnv, input int hold,
                        input bit noise, output int acc_cyc);
        int w, de, be, cnt;
        w = sel ? 1 : 4;
        model(w, av, bv, bnv, de, be);
        ordy = (hold == 0);
        chk("in_ready_idle", 32'(ir), 1);
        a = 4'(av); b = 4'(bv); bin = 1'(bnv);
        set_iv(1'b1);
        @(negedge CLK);
        acc_cyc = cyc;
        set_iv(1'b0);
        cnt = 0;
        while (ov !== 1'b1 && cnt < 40) begin
            if (cnt == 0) chk("in_ready_run", 32'(ir), 0);
            if (noise) noise_inputs();
            @(negedge CLK);
            cnt++;
        end
        set_iv(1'b0);
        chk("latency", cnt, w);
        chk("diff", 32'(d), de);
        chk("bout", 32'(bo), be);
        chk("in_ready_done", 32'(ir), 0);
        repeat (hold) begin
            if (noise) noise_inputs();
            @(negedge CLK);
            chk("hold_valid", 32'(ov), 1);
            chk("hold_diff", 32'(d), de);
            chk("hold_bout", 32'(bo), be);
        end
        set_iv(1'b0);
        ordy = 1'b1;
        @(negedge CLK);
        chk("release_valid", 32'(ov), 0);
        chk("release_ready", 32'(ir), 1);
    endtask

    initial begin
        int acc, prev;
        RESET_N = 1'b0; iv4 = 1'b0; iv1 = 1'b0; sel = 1'b0;
        a = '0; b = '0; bin = 1'b0; ordy = 1'b0;
        #3;
        chk("rst_ready4", 32'(ir4), 1);
        chk("rst_valid4", 32'(ov4), 0);
        chk("rst_d4", 32'(d4), 0);
        chk("rst_bout4", 32'(bo4), 0);
        chk("rst_ready1", 32'(ir1), 1);
        chk("rst_valid1", 32'(ov1), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Directed cases on the 4-bit instance
        xact(9, 3, 0, 0, 0, acc);
        xact(3, 9, 0, 0, 0, acc);
        xact(0, 0, 1, 0, 0, acc);
        xact(5, 5, 0, 0, 0, acc);
        xact(15, 15, 1, 0, 0, acc);
        xact(12, 4, 0, 6, 1, acc);

        // Abort during the second RUN cycle
        a = 4'd5; b = 4'd2; bin = 1'b0; iv4 = 1'b1;
        @(negedge CLK);
        iv4 = 1'b0;
        @(negedge CLK);
        chk("pre_rst_d", 32'(d4), 32'h8);
        #2 RESET_N = 1'b0;
        #1;
        chk("abort_run_valid", 32'(ov4), 0);
        chk("abort_run_d", 32'(d4), 0);
        chk("abort_run_bout", 32'(bo4), 0);
        chk("abort_run_ready", 32'(ir4), 1);
        @(negedge CLK);
        RESET_N = 1'b1;
        xact(7, 2, 0, 0, 0, acc);

        // Abort while a result waits in DONE
        ordy = 1'b0;
        a = 4'd2; b = 4'd9; bin = 1'b1; iv4 = 1'b1;
        @(negedge CLK);
        iv4 = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_valid", 32'(ov4), 1);
        chk("pre_rst_bout", 32'(bo4), 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("abort_done_valid", 32'(ov4), 0);
        chk("abort_done_d", 32'(d4), 0);
        chk("abort_done_bout", 32'(bo4), 0);
        chk("abort_done_ready", 32'(ir4), 1);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Random operands, random backpressure and input noise
        repeat (40)
            xact(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1, acc);

        // Exhaustive back-to-back sweeps; accepts must be WIDTH+2 cycles apart
        for (int s = 0; s < 2; s++) begin
            int w;
            sel = s[0];
            w = sel ? 1 : 4;
            prev = -1;
            for (int av = 0; av < (1 << w); av++)
                for (int bv = 0; bv < (1 << w); bv++)
                    for (int bn = 0; bn < 2; bn++) begin
                        xact(av, bv, bn, 0, 0, acc);
                        if (prev >= 0) chk("spacing", acc - prev, w + 2);
                        prev = acc;
                    end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
